// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ack handshake, framing-error strobe and sticky overrun flag.
// Optional `define UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each bit centre.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic       clockIN,
  input  logic       nRxResetIN,
  input  logic       rxIN,
  input  logic       rxAckIN,
  output logic [7:0] rxDataOUT,
  output logic       rxValidOUT,
  output logic       rxBusyOUT,
  output logic       rxFramingErrorOUT,
  output logic       rxOverrunOUT
);

  localparam int BIT_PERIOD  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CW          = $clog2(BIT_PERIOD);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_DELAY  = 1;
`else
  localparam int VOTE_DELAY  = 0;
`endif
  localparam logic [CW-1:0] START_LAST = CW'(HALF_PERIOD - 1 + VOTE_DELAY);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rxState_t;

  logic [1:0]    r_resetSync;
  logic          w_rstN;
  logic          r_sync1;
  logic          r_rxS;
  logic          r_rxSPrev;
  logic          w_sample;
  rxState_t      r_state;
  rxState_t      w_stateNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic [2:0]    r_index;
  logic [2:0]    w_indexNext;
  logic [7:0]    r_shift;
  logic [7:0]    w_shiftNext;
  logic          w_byteDone;
  logic          w_framingError;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_framingError;
  logic          r_overrun;

  // Reset asserts asynchronously but is released only on a clock edge.
  always_ff @(posedge clockIN or negedge nRxResetIN) begin
    if (!nRxResetIN) begin
      r_resetSync <= 2'b00;
    end else begin
      r_resetSync <= {r_resetSync[0], 1'b1};
    end
  end

  assign w_rstN = r_resetSync[1];

  always_ff @(posedge clockIN or negedge w_rstN) begin
    if (!w_rstN) begin
      r_sync1   <= 1'b1;
      r_rxS     <= 1'b1;
      r_rxSPrev <= 1'b1;
    end else begin
      r_sync1   <= rxIN;
      r_rxS     <= r_sync1;
      r_rxSPrev <= r_rxS;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_rxSPrev2;

  always_ff @(posedge clockIN or negedge w_rstN) begin
    if (!w_rstN) begin
      r_rxSPrev2 <= 1'b1;
    end else begin
      r_rxSPrev2 <= r_rxSPrev;
    end
  end

  // Decided one clock after the centre so centre-1, centre and centre+1 are all visible.
  assign w_sample = (r_rxS & r_rxSPrev) | (r_rxS & r_rxSPrev2) | (r_rxSPrev & r_rxSPrev2);
`else
  assign w_sample = r_rxS;
`endif

  always_ff @(posedge clockIN or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_index <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_index <= w_indexNext;
      r_shift <= w_shiftNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count + COUNT_ONE;
    w_indexNext    = r_index;
    w_shiftNext    = r_shift;
    w_byteDone     = 1'b0;
    w_framingError = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_countNext = '0;
        if (!r_rxS && r_rxSPrev) begin
          w_stateNext = S_START;
        end
      end
      S_START: begin
        if (r_count == START_LAST) begin
          w_countNext = '0;
          w_indexNext = 3'd0;
          w_stateNext = w_sample ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_count == BIT_LAST) begin
          w_countNext          = '0;
          w_shiftNext[r_index] = w_sample;
          if (r_index == 3'd7) begin
            w_stateNext = S_STOP;
          end else begin
            w_indexNext = r_index + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_count == BIT_LAST) begin
          w_countNext = '0;
          if (w_sample) begin
            w_byteDone  = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_framingError = 1'b1;
            w_stateNext    = S_BREAK;
          end
        end
      end
      // A line held low after a bad stop bit must go idle before a new start is accepted.
      S_BREAK: begin
        w_countNext = '0;
        if (r_rxS) begin
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_countNext = '0;
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clockIN or negedge w_rstN) begin
    if (!w_rstN) begin
      r_data         <= 8'h00;
      r_valid        <= 1'b0;
      r_framingError <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_framingError <= w_framingError;
      if (w_byteDone) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !rxAckIN) begin
          r_overrun <= 1'b1;
        end
      end else if (rxAckIN) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rxDataOUT         = r_data;
  assign rxValidOUT        = r_valid;
  assign rxBusyOUT         = (r_state != S_IDLE);
  assign rxFramingErrorOUT = r_framingError;
  assign rxOverrunOUT      = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit: directed scenarios plus randomized frames,
// checked every cycle against a frame-timing model of the receiver.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;

  logic       clockIN;
  logic       nRxResetIN;
  logic       rxIN;
  logic       rxAckIN;
  logic [7:0] rxDataOUT;
  logic       rxValidOUT;
  logic       rxBusyOUT;
  logic       rxFramingErrorOUT;
  logic       rxOverrunOUT;

  int checks     = 0;
  int failures   = 0;
  bit compareOn  = 1'b0;
  int ferrPulses = 0;
  int busyCycles = 0;

  uart_rx #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE      (BAUD)
  ) dut (
    .clockIN          (clockIN),
    .nRxResetIN       (nRxResetIN),
    .rxIN             (rxIN),
    .rxAckIN          (rxAckIN),
    .rxDataOUT        (rxDataOUT),
    .rxValidOUT       (rxValidOUT),
    .rxBusyOUT        (rxBusyOUT),
    .rxFramingErrorOUT(rxFramingErrorOUT),
    .rxOverrunOUT     (rxOverrunOUT)
  );

  initial begin
    clockIN = 1'b0;
    forever #5 clockIN = ~clockIN;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, actual, expected, $time);
    end
  endtask

  // Receiver model: after a falling edge on the synchronised line, decision j
  // (0 = start, 1..8 = data LSB first, 9 = stop) lands HALF + j*BIT clocks later.
  typedef enum {M_IDLE, M_FRAME, M_BREAK} modelMode_t;
  modelMode_t mMode;
  int         cycleNo = 0;
  int         frameStart;
  logic       l1, l2, l3;
  logic [7:0] mBits;
  logic [7:0] expData;
  logic       expValid, expBusy, expFerr, expOvr;

  always @(posedge clockIN or negedge nRxResetIN) begin : model
    int   k;
    int   idx;
    logic s1, s2, mDone, mFerr;
    cycleNo++;
    if (!nRxResetIN) begin
      mMode    = M_IDLE;
      l1       = 1'b1;
      l2       = 1'b1;
      l3       = 1'b1;
      mBits    = 8'h00;
      expData  = 8'h00;
      expValid = 1'b0;
      expBusy  = 1'b0;
      expFerr  = 1'b0;
      expOvr   = 1'b0;
    end else begin
      s1    = l2;
      s2    = l3;
      mDone = 1'b0;
      mFerr = 1'b0;
      case (mMode)
        M_IDLE: begin
          if (!s1 && s2) begin
            mMode      = M_FRAME;
            frameStart = cycleNo;
          end
        end
        M_FRAME: begin
          k = cycleNo - frameStart;
          if (k == HALF) begin
            if (s1) mMode = M_IDLE;
          end else if (k >= HALF + BIT && k <= HALF + 8 * BIT && (k - HALF) % BIT == 0) begin
            idx = (k - HALF) / BIT - 1;
            mBits[idx[2:0]] = s1;
          end else if (k == HALF + 9 * BIT) begin
            if (s1) begin
              mDone = 1'b1;
              mMode = M_IDLE;
            end else begin
              mFerr = 1'b1;
              mMode = M_BREAK;
            end
          end
        end
        M_BREAK: begin
          if (s1) mMode = M_IDLE;
        end
        default: mMode = M_IDLE;
      endcase
      if (mDone) begin
        if (expValid && !rxAckIN) expOvr = 1'b1;
        expValid = 1'b1;
        expData  = mBits;
      end else if (rxAckIN) begin
        expValid = 1'b0;
      end
      expFerr = mFerr;
      expBusy = (mMode != M_IDLE);
      l3 = l2;
      l2 = l1;
      l1 = rxIN;
    end
  end

  always @(negedge clockIN) begin
    if (compareOn) begin
      checkOutput("outputs",
                  32'({rxDataOUT, rxValidOUT, rxBusyOUT, rxFramingErrorOUT, rxOverrunOUT}),
                  32'({expData, expValid, expBusy, expFerr, expOvr}));
      if (rxFramingErrorOUT) ferrPulses++;
      if (rxBusyOUT) busyCycles++;
    end
  end

  // All drive actions happen 2 time units after a rising edge.
  task automatic driveBit(input logic v, input int n);
    rxIN = v;
    if (n > 0) begin
      repeat (n) @(posedge clockIN);
      #2;
    end
  endtask

  task automatic idleLine(input int n);
    driveBit(1'b1, n);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int lowAfter);
    driveBit(1'b0, BIT);
    for (int i = 0; i < 8; i++) driveBit(b[i], BIT);
    driveBit(stopBit, BIT);
    if (!stopBit && lowAfter > 0) driveBit(1'b0, lowAfter);
    rxIN = 1'b1;
  endtask

  task automatic ackPulse;
    rxAckIN = 1'b1;
    @(posedge clockIN);
    #2;
    rxAckIN = 1'b0;
  endtask

  task automatic waitValid(input int maxCycles, output int cyclesTaken);
    cyclesTaken = -1;
    for (int c = 1; c <= maxCycles; c++) begin
      @(posedge clockIN);
      @(negedge clockIN);
      if (rxValidOUT) begin
        cyclesTaken = c;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          ferrBase;
    int          busyBase;
    logic [31:0] v;
    logic [7:0]  got[$];
    bit          randomDone;

    rxIN       = 1'b1;
    rxAckIN    = 1'b0;
    nRxResetIN = 1'b0;
    @(posedge clockIN);
    #2;
    compareOn = 1'b1;
    @(posedge clockIN);
    #2;
    checkOutput("reset_state",
                32'({rxDataOUT, rxValidOUT, rxBusyOUT, rxFramingErrorOUT, rxOverrunOUT}), 32'h0);
    nRxResetIN = 1'b1;
    idleLine(5);

    $display("[TB] single frame 0xA5");
    fork
      applyStimulus(8'hA5, 1'b1, 0);
      begin
        waitValid(200, lat);
        checkOutput("t1_latency", lat, 98);
        checkOutput("t1_data", 32'(rxDataOUT), 32'hA5);
        checkOutput("t1_ferr", 32'(rxFramingErrorOUT), 32'h0);
      end
    join
    idleLine(3);
    ackPulse();
    idleLine(2);
    checkOutput("t1_acked", 32'(rxValidOUT), 32'h0);

    $display("[TB] overrun 0x3C then 0xC3");
    applyStimulus(8'h3C, 1'b1, 0);
    idleLine(5);
    applyStimulus(8'hC3, 1'b1, 0);
    idleLine(5);
    checkOutput("t2_data", 32'(rxDataOUT), 32'hC3);
    checkOutput("t2_overrun", 32'(rxOverrunOUT), 32'h1);
    checkOutput("t2_valid", 32'(rxValidOUT), 32'h1);
    ackPulse();
    checkOutput("t2_valid_cleared", 32'(rxValidOUT), 32'h0);
    checkOutput("t2_overrun_sticky", 32'(rxOverrunOUT), 32'h1);

    $display("[TB] framing error and held-low line");
    ferrBase = ferrPulses;
    applyStimulus(8'h55, 1'b0, 30);
    checkOutput("t3_busy_in_break", 32'(rxBusyOUT), 32'h1);
    idleLine(10);
    checkOutput("t3_ferr_pulses", ferrPulses - ferrBase, 1);
    checkOutput("t3_valid", 32'(rxValidOUT), 32'h0);
    checkOutput("t3_busy_after", 32'(rxBusyOUT), 32'h0);

    $display("[TB] 3-clock glitch");
    busyBase = busyCycles;
    driveBit(1'b0, 3);
    idleLine(20);
    checkOutput("t4_busy_seen", 32'(busyCycles > busyBase), 32'h1);
    checkOutput("t4_busy", 32'(rxBusyOUT), 32'h0);
    checkOutput("t4_valid", 32'(rxValidOUT), 32'h0);

    $display("[TB] back-to-back 0x00 0xFF");
    got.delete();
    fork
      begin
        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, 0);
        idleLine(20);
      end
      begin
        for (int f = 0; f < 2; f++) begin
          waitValid(300, lat);
          if (lat > 0) begin
            got.push_back(rxDataOUT);
            @(posedge clockIN);
            #2;
            ackPulse();
          end
        end
      end
    join
    checkOutput("t5_count", got.size(), 2);
    v = (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF;
    checkOutput("t5_first", v, 32'h00);
    v = (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF;
    checkOutput("t5_second", v, 32'hFF);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h7E, 1'b1, 0);
    idleLine(5);
    fork
      applyStimulus(8'h5A, 1'b1, 0);
      begin
        repeat (55) @(posedge clockIN);
        #3;
        nRxResetIN = 1'b0;
        #1;
        checkOutput("t6_reset_outputs",
                    32'({rxDataOUT, rxValidOUT, rxBusyOUT, rxFramingErrorOUT, rxOverrunOUT}), 32'h0);
      end
    join
    idleLine(3);
    nRxResetIN = 1'b1;
    idleLine(10);
    fork
      applyStimulus(8'h81, 1'b1, 0);
      begin
        waitValid(200, lat);
        checkOutput("t6_valid_seen", 32'(lat > 0), 32'h1);
        checkOutput("t6_data", 32'(rxDataOUT), 32'h81);
        checkOutput("t6_overrun", 32'(rxOverrunOUT), 32'h0);
      end
    join
    idleLine(3);
    ackPulse();
    idleLine(5);

    $display("[TB] randomized frames");
    randomDone = 1'b0;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          logic [7:0] b;
          logic       sb;
          int         low;
          if ($urandom_range(0, 4) == 0) begin
            driveBit(1'b0, int'($urandom_range(1, 3)));
            idleLine(8);
          end
          b   = 8'($urandom);
          sb  = ($urandom_range(0, 7) != 0);
          low = sb ? 0 : int'($urandom_range(0, 25));
          applyStimulus(b, sb, low);
          idleLine(int'($urandom_range(0, 12)));
        end
        idleLine(150);
        randomDone = 1'b1;
      end
      begin
        while (!randomDone) begin
          rxAckIN = ($urandom_range(0, 3) == 0);
          @(posedge clockIN);
          #2;
        end
        rxAckIN = 1'b0;
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
